// File: rtl/exe_pkg.sv
// Shared encodings for the execute stage: ALU command codes, branch types
// and the multiply sequencer state.
package exe_pkg;

    typedef enum logic [3:0] {
        CMD_ADD = 4'b0000,
        CMD_SUB = 4'b0010,
        CMD_AND = 4'b0100,
        CMD_OR  = 4'b0101,
        CMD_NOR = 4'b0110,
        CMD_XOR = 4'b0111,
        CMD_SLL = 4'b1000,
        CMD_SRL = 4'b1001,
        CMD_SRA = 4'b1010,
        CMD_MUL = 4'b1100
    } exe_cmd_e;

    typedef enum logic [1:0] {
        BR_NONE = 2'd0,
        BR_BEZ  = 2'd1,
        BR_BNE  = 2'd2,
        BR_JMP  = 2'd3
    } br_type_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/exe_stage_if.sv
// ID/EX side inputs and EX/MEM side outputs of the execute stage.
// The master drives the decoded instruction; the slave is the execute stage.
interface exe_stage_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] Val1;
    logic [WIDTH-1:0] Val2;
    logic [WIDTH-1:0] Reg2;
    logic [WIDTH-1:0] PC_in;
    logic [3:0]       EXE_CMD;
    logic [1:0]       br_type;
    logic [4:0]       Dest_in;
    logic             MEM_R_EN_in;
    logic             MEM_W_EN_in;
    logic             WB_EN_in;

    logic [WIDTH-1:0] ALU_result;
    logic             Br_taken;
    logic [WIDTH-1:0] Br_addr;
    logic             Stall;
    logic [4:0]       Dest_out;
    logic [WIDTH-1:0] Reg2_out;
    logic             MEM_R_EN_out;
    logic             MEM_W_EN_out;
    logic             WB_EN_out;

    modport master (
        output Val1, Val2, Reg2, PC_in, EXE_CMD, br_type, Dest_in,
               MEM_R_EN_in, MEM_W_EN_in, WB_EN_in,
        input  ALU_result, Br_taken, Br_addr, Stall, Dest_out, Reg2_out,
               MEM_R_EN_out, MEM_W_EN_out, WB_EN_out
    );

    modport slave (
        input  Val1, Val2, Reg2, PC_in, EXE_CMD, br_type, Dest_in,
               MEM_R_EN_in, MEM_W_EN_in, WB_EN_in,
        output ALU_result, Br_taken, Br_addr, Stall, Dest_out, Reg2_out,
               MEM_R_EN_out, MEM_W_EN_out, WB_EN_out
    );

endinterface

// File: rtl/exe_stage_seq_multiplier.sv
// Iterative shift-and-add signed multiplier: one multiplier bit per cycle on
// operand magnitudes, sign applied to the low WIDTH bits of the product.
module seq_multiplier
    import exe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             idle,
    output logic [WIDTH-1:0] product
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WIDTH - 1);

    mul_state_e       state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             sign_q, sign_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            sign_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            sign_q   <= sign_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        count_d  = count_q;
        sign_d   = sign_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mcand_d  = a[WIDTH-1] ? -a : a;
                    mplier_d = b[WIDTH-1] ? -b : b;
                    sign_d   = a[WIDTH-1] ^ b[WIDTH-1];
                    acc_d    = '0;
                    count_d  = '0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + CNT_W'(1);
                // The WIDTH-th run cycle is the one that sees LAST_COUNT.
                if (count_q == LAST_COUNT) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy    = ((state_q == ST_IDLE) && start) || (state_q == ST_RUN);
        done    = (state_q == ST_DONE);
        idle    = (state_q == ST_IDLE);
        product = sign_q ? -acc_q : acc_q;
    end

endmodule

// File: rtl/exe_stage.sv
// MIPS execute stage: single-cycle ALU, branch/jump resolution, and a
// sequential multiply that stalls upstream and bubbles EX/MEM while running.
module exe_stage
    import exe_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int BR_SHIFT = 2
) (
    input  logic        clk,
    input  logic        rst,
    exe_stage_if.slave  bus
);
    logic [WIDTH-1:0] alu_out;
    logic [4:0]       shamt;
    logic             mul_start;
    logic             mul_busy;
    logic             mul_done;
    logic             mul_idle;
    logic [WIDTH-1:0] mul_product;
    logic             br_cond;
    logic             stall;

    assign mul_start = (bus.EXE_CMD == CMD_MUL);
    assign shamt     = bus.Val2[4:0];

    seq_multiplier #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (bus.Val1),
        .b       (bus.Val2),
        .busy    (mul_busy),
        .done    (mul_done),
        .idle    (mul_idle),
        .product (mul_product)
    );

    always_comb begin
        alu_out = '0;
        case (bus.EXE_CMD)
            CMD_ADD: alu_out = bus.Val1 + bus.Val2;
            CMD_SUB: alu_out = bus.Val1 - bus.Val2;
            CMD_AND: alu_out = bus.Val1 & bus.Val2;
            CMD_OR:  alu_out = bus.Val1 | bus.Val2;
            CMD_NOR: alu_out = ~(bus.Val1 | bus.Val2);
            CMD_XOR: alu_out = bus.Val1 ^ bus.Val2;
            CMD_SLL: alu_out = bus.Val1 << shamt;
            CMD_SRL: alu_out = bus.Val1 >> shamt;
            CMD_SRA: alu_out = $unsigned($signed(bus.Val1) >>> shamt);
            default: alu_out = '0;
        endcase
    end

    always_comb begin
        br_cond = 1'b0;
        case (bus.br_type)
            BR_BEZ:  br_cond = (bus.Val1 == '0);
            BR_BNE:  br_cond = (bus.Val1 != bus.Reg2);
            BR_JMP:  br_cond = 1'b1;
            default: br_cond = 1'b0;
        endcase
    end

    // Reset forces the visible outputs quiet even before the first edge.
    always_comb begin
        stall            = rst && mul_busy;
        bus.Stall        = stall;
        bus.Br_taken     = rst && mul_idle && br_cond;
        bus.Br_addr      = bus.PC_in + (bus.Val2 << BR_SHIFT);
        bus.ALU_result   = !rst ? '0 : (mul_done ? mul_product : alu_out);
        bus.MEM_R_EN_out = rst && !stall && bus.MEM_R_EN_in;
        bus.MEM_W_EN_out = rst && !stall && bus.MEM_W_EN_in;
        bus.WB_EN_out    = rst && !stall && bus.WB_EN_in;
        bus.Dest_out     = bus.Dest_in;
        bus.Reg2_out     = bus.Reg2;
    end

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: inputs change on the falling edge and
// outputs are sampled 1ns later, well clear of the rising edge.
module tb_exe_stage;
    import exe_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    exe_stage_if #(.WIDTH(32)) bus ();

    exe_stage #(
        .WIDTH    (32),
        .BR_SHIFT (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic drive(input logic [3:0] cmd, input logic [31:0] v1, input logic [31:0] v2,
                         input logic [31:0] r2, input logic [31:0] pc, input logic [1:0] bt,
                         input logic wb, input logic mr, input logic mw, input logic [4:0] dest);
        bus.EXE_CMD     = cmd;
        bus.Val1        = v1;
        bus.Val2        = v2;
        bus.Reg2        = r2;
        bus.PC_in       = pc;
        bus.br_type     = bt;
        bus.WB_EN_in    = wb;
        bus.MEM_R_EN_in = mr;
        bus.MEM_W_EN_in = mw;
        bus.Dest_in     = dest;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        @(negedge clk);
        drive(CMD_ADD, 32'd5, 32'd6, 32'd0, 32'h100, BR_JMP, 1'b1, 1'b1, 1'b1, 5'd3);
        @(negedge clk);
        #1;
        checks++;
        if (bus.ALU_result !== 32'h0 || bus.Stall !== 1'b0 || bus.Br_taken !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got alu=%h stall=%b br=%b want alu=0 stall=0 br=0",
                     bus.ALU_result, bus.Stall, bus.Br_taken);
        end
        checks++;
        if ({bus.WB_EN_out, bus.MEM_R_EN_out, bus.MEM_W_EN_out} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_ctrl got %b want 000",
                     {bus.WB_EN_out, bus.MEM_R_EN_out, bus.MEM_W_EN_out});
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_alu();
        logic [3:0]  cmds [10] = '{CMD_ADD, CMD_SUB, CMD_AND, CMD_OR, CMD_NOR,
                                   CMD_XOR, CMD_SRA, CMD_SLL, CMD_SRL, 4'b0011};
        logic [31:0] v1s  [10] = '{32'd5, 32'd3, 32'hF0F000FF, 32'hF0F000FF, 32'hF0F000FF,
                                   32'hF0F000FF, 32'h80000000, 32'h40000001, 32'h80000000, 32'hFFFFFFFF};
        logic [31:0] v2s  [10] = '{32'hFFFFFFFD, 32'd5, 32'h0FF00F0F, 32'h0FF00F0F, 32'h0FF00F0F,
                                   32'h0FF00F0F, 32'd4, 32'd33, 32'd31, 32'hFFFFFFFF};
        logic [31:0] exps [10] = '{32'd2, 32'hFFFFFFFE, 32'h00F0000F, 32'hFFF00FFF, 32'h000FF000,
                                   32'hFF000FF0, 32'hF8000000, 32'h80000002, 32'd1, 32'd0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(cmds[i], v1s[i], v2s[i], 32'hABCD0000 + i, 32'h0, BR_NONE, 1'b1, 1'b1, 1'b0, 5'(i + 1));
            #1;
            checks++;
            if (bus.ALU_result !== exps[i]) begin
                errors++;
                $display("[TB] FAIL alu_%0d got %h want %h", i, bus.ALU_result, exps[i]);
            end
            checks++;
            if (bus.Stall !== 1'b0 || bus.WB_EN_out !== 1'b1 || bus.MEM_R_EN_out !== 1'b1 ||
                bus.MEM_W_EN_out !== 1'b0) begin
                errors++;
                $display("[TB] FAIL alu_ctrl_%0d got stall=%b wb=%b mr=%b mw=%b want 0 1 1 0",
                         i, bus.Stall, bus.WB_EN_out, bus.MEM_R_EN_out, bus.MEM_W_EN_out);
            end
            checks++;
            if (bus.Dest_out !== 5'(i + 1) || bus.Reg2_out !== 32'hABCD0000 + i) begin
                errors++;
                $display("[TB] FAIL passthru_%0d got dest=%0d reg2=%h want %0d %h",
                         i, bus.Dest_out, bus.Reg2_out, i + 1, 32'hABCD0000 + i);
            end
        end
    endtask

    task automatic test_branch();
        logic [1:0]  bts  [7] = '{BR_BEZ, BR_BEZ, BR_BNE, BR_BNE, BR_JMP, BR_NONE, BR_JMP};
        logic [31:0] v1s  [7] = '{32'd0, 32'd1, 32'd7, 32'd7, 32'd9, 32'd0, 32'd0};
        logic [31:0] r2s  [7] = '{32'd0, 32'd0, 32'd7, 32'd8, 32'd9, 32'd0, 32'd0};
        logic [31:0] pcs  [7] = '{32'h100, 32'h100, 32'h200, 32'h200, 32'h40, 32'h100, 32'hFFFFFFFC};
        logic [31:0] v2s  [7] = '{32'd3, 32'd3, 32'd1, 32'd1, 32'hFFFFFFFF, 32'd3, 32'd2};
        logic        tks  [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [31:0] ads  [7] = '{32'h10C, 32'h10C, 32'h204, 32'h204, 32'h3C, 32'h10C, 32'h4};
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            drive(CMD_ADD, v1s[i], v2s[i], r2s[i], pcs[i], bts[i], 1'b0, 1'b0, 1'b0, 5'd0);
            #1;
            checks++;
            if (bus.Br_taken !== tks[i] || bus.Br_addr !== ads[i]) begin
                errors++;
                $display("[TB] FAIL branch_%0d got taken=%b addr=%h want %b %h",
                         i, bus.Br_taken, bus.Br_addr, tks[i], ads[i]);
            end
        end
    endtask

    // Drives a MUL and follows it through to its DONE cycle.
    task automatic run_mul(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] expected, output int stall_cycles);
        bit bubble_ok;
        @(negedge clk);
        drive(CMD_MUL, a, b, 32'h0, 32'h0, BR_NONE, 1'b1, 1'b1, 1'b1, 5'd9);
        #1;
        stall_cycles = 0;
        bubble_ok = 1'b1;
        while (bus.Stall === 1'b1 && stall_cycles < 100) begin
            if (bus.WB_EN_out !== 1'b0 || bus.MEM_R_EN_out !== 1'b0 || bus.MEM_W_EN_out !== 1'b0)
                bubble_ok = 1'b0;
            stall_cycles++;
            @(negedge clk);
            #1;
        end
        checks++;
        if (stall_cycles != 33) begin
            errors++;
            $display("[TB] FAIL %s_stall got %0d want 33", name, stall_cycles);
        end
        checks++;
        if (!bubble_ok) begin
            errors++;
            $display("[TB] FAIL %s_bubble got ctrl high while stalled want 0", name);
        end
        checks++;
        if (bus.ALU_result !== expected || bus.WB_EN_out !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s_done got alu=%h wb=%b want %h 1", name, bus.ALU_result,
                     bus.WB_EN_out, expected);
        end
    endtask

    task automatic test_mul();
        int n;
        run_mul("mul_7x-3", 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, n);
    endtask

    task automatic test_back_to_back();
        int n1;
        int n2;
        run_mul("b2b_first", 32'd3, 32'd4, 32'd12, n1);
        run_mul("b2b_second", 32'h10000, 32'h10000, 32'd0, n2);
        checks++;
        if (n1 + n2 != 66) begin
            errors++;
            $display("[TB] FAIL b2b_total_stall got %0d want 66", n1 + n2);
        end
        @(negedge clk);
        drive(CMD_OR, 32'h5, 32'h2, 32'h0, 32'h0, BR_NONE, 1'b1, 1'b0, 1'b0, 5'd1);
        #1;
        checks++;
        if (bus.ALU_result !== 32'h7 || bus.Stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_single_done got alu=%h stall=%b want 7 0",
                     bus.ALU_result, bus.Stall);
        end
    endtask

    task automatic test_reset_mid_run();
        int n;
        @(negedge clk);
        drive(CMD_MUL, 32'd9, 32'd9, 32'h0, 32'h0, BR_NONE, 1'b1, 1'b0, 1'b0, 5'd2);
        repeat (11) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (bus.Stall !== 1'b0 || bus.ALU_result !== 32'h0 || bus.WB_EN_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rst_run_outputs got stall=%b alu=%h wb=%b want 0 0 0",
                     bus.Stall, bus.ALU_result, bus.WB_EN_out);
        end
        @(negedge clk);
        rst = 1'b1;
        drive(CMD_ADD, 32'd1, 32'd2, 32'h0, 32'h0, BR_NONE, 1'b1, 1'b0, 1'b0, 5'd2);
        #1;
        checks++;
        if (bus.Stall !== 1'b0 || bus.ALU_result !== 32'd3 || bus.WB_EN_out !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rst_run_idle got stall=%b alu=%h wb=%b want 0 3 1",
                     bus.Stall, bus.ALU_result, bus.WB_EN_out);
        end
        run_mul("rst_reissue", 32'd6, 32'd6, 32'd36, n);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        drive(CMD_ADD, 32'h0, 32'h0, 32'h0, 32'h0, BR_NONE, 1'b0, 1'b0, 1'b0, 5'd0);
        test_reset();
        test_alu();
        test_branch();
        test_mul();
        test_back_to_back();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
